// File: rtl/act_sram_responder.sv
// act_sram_responder
//   Activation scratchpad SRAM bank shared by the element-wise op engines
//   (fixed-timing port, never stalled) and a host/DMA port (valid/ready,
//   only granted on cycles the engine leaves idle). It also keeps a sticky
//   out-of-range flag and read/write access counters.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   eng_rd_en/addr      engine read; eng_rd_data is valid the cycle after
//   eng_wr_en/addr/data engine write, commits at the clock edge
//   host_req_*          host request; accepted when valid & ready
//   host_rsp_valid      one-cycle pulse the cycle after acceptance
//   host_rsp_rdata      host read data (unchanged by host writes)
//   err_oob, err_clr    sticky out-of-range flag and its clear (also clears counters)
//   rd_count, wr_count  granted reads / committed in-range writes
//
// Optional build macro: ACT_SRAM_PARITY_EN
//   Adds an even-parity bit per word, checked on every read, reported on the
//   sticky err_parity output. inj_par_err flips the stored parity bit of the
//   write in the same cycle.

module act_sram_responder #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4096,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              eng_rd_en,
  input  logic [ADDR_W-1:0] eng_rd_addr,
  output logic [DATA_W-1:0] eng_rd_data,
  input  logic              eng_wr_en,
  input  logic [ADDR_W-1:0] eng_wr_addr,
  input  logic [DATA_W-1:0] eng_wr_data,
  input  logic              host_req_valid,
  output logic              host_req_ready,
  input  logic              host_req_we,
  input  logic [ADDR_W-1:0] host_req_addr,
  input  logic [DATA_W-1:0] host_req_wdata,
  output logic              host_rsp_valid,
  output logic [DATA_W-1:0] host_rsp_rdata,
  output logic              err_oob,
  input  logic              err_clr,
`ifdef ACT_SRAM_PARITY_EN
  input  logic              inj_par_err,
  output logic              err_parity,
`endif
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              r_eng_rd_data;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_err_oob;
  logic [CNT_W-1:0]  r_rd_count;
  logic [CNT_W-1:0]  r_wr_count;

  logic              w_host_acc;
  logic              w_host_rd;
  logic              w_rd_go;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_rd_oob;
  logic [IDX_W-1:0]  w_rd_idx;
  logic              w_wr_go;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic              w_wr_oob;
  logic              w_wr_commit;
  logic [IDX_W-1:0]  w_wr_idx;
  logic              w_bypass;
  logic [DATA_W-1:0] w_rd_word;
  logic              w_oob_evt;

  // The engine owns the bank whenever it strobes; the host only fills gaps.
  assign host_req_ready = !eng_rd_en && !eng_wr_en;
  assign w_host_acc     = host_req_valid && host_req_ready;
  assign w_host_rd      = w_host_acc && !host_req_we;

  // Engine and host accesses are mutually exclusive, so one shared read
  // port and one shared write port are enough.
  assign w_rd_go   = eng_rd_en || w_host_rd;
  assign w_rd_addr = eng_rd_en ? eng_rd_addr : host_req_addr;
  assign w_wr_go   = eng_wr_en || (w_host_acc && host_req_we);
  assign w_wr_addr = eng_wr_en ? eng_wr_addr : host_req_addr;
  assign w_wr_data = eng_wr_en ? eng_wr_data : host_req_wdata;

  // One extra bit so that DEPTH == 2**ADDR_W still compares correctly.
  assign w_rd_oob    = ({1'b0, w_rd_addr} >= DEPTH_L);
  assign w_wr_oob    = ({1'b0, w_wr_addr} >= DEPTH_L);
  assign w_wr_commit = w_wr_go && !w_wr_oob;
  assign w_rd_idx    = w_rd_addr[IDX_W-1:0];
  assign w_wr_idx    = w_wr_addr[IDX_W-1:0];

  // Same-cycle read and write of one address return the new data.
  assign w_bypass  = w_rd_go && w_wr_commit && (w_rd_addr == w_wr_addr);

  always_comb begin
    w_rd_word = '0;
    if (!w_rd_oob) begin
      w_rd_word = w_bypass ? w_wr_data : r_mem[w_rd_idx];
    end
  end

  assign w_oob_evt = (w_rd_go && w_rd_oob) || (w_wr_go && w_wr_oob);

  // Storage is not reset.
  always_ff @(posedge clk) begin
    if (w_wr_commit) begin
      r_mem[w_wr_idx] <= w_wr_data;
    end
  end

  // Read data, response and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_err_oob   <= 1'b0;
      r_rd_count  <= '0;
      r_wr_count  <= '0;
    end else begin
      r_rsp_valid <= w_host_acc;
      if (w_rd_go) begin
        r_rd_data <= w_rd_word;
      end
      if (w_host_rd) begin
        r_rsp_rdata <= w_rd_word;
      end
      // A new error in the same cycle as err_clr wins.
      if (w_oob_evt) begin
        r_err_oob <= 1'b1;
      end else if (err_clr) begin
        r_err_oob <= 1'b0;
      end
      if (err_clr) begin
        r_rd_count <= '0;
        r_wr_count <= '0;
      end else begin
        r_rd_count <= r_rd_count + CNT_W'(w_rd_go);
        r_wr_count <= r_wr_count + CNT_W'(w_wr_commit);
      end
    end
  end

`ifdef ACT_SRAM_PARITY_EN
  logic r_par [DEPTH];
  logic r_err_par;
  logic w_wr_par;
  logic w_rd_par;
  logic w_par_evt;

  assign w_wr_par  = (^w_wr_data) ^ inj_par_err;
  assign w_rd_par  = w_bypass ? w_wr_par : r_par[w_rd_idx];
  assign w_par_evt = w_rd_go && !w_rd_oob && ((^w_rd_word) != w_rd_par);

  always_ff @(posedge clk) begin
    if (w_wr_commit) begin
      r_par[w_wr_idx] <= w_wr_par;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_par <= 1'b0;
    end else if (w_par_evt) begin
      r_err_par <= 1'b1;
    end else if (err_clr) begin
      r_err_par <= 1'b0;
    end
  end

  assign err_parity = r_err_par;
`endif

  assign eng_rd_data    = r_rd_data;
  assign host_rsp_valid = r_rsp_valid;
  assign host_rsp_rdata = r_rsp_rdata;
  assign err_oob        = r_err_oob;
  assign rd_count       = r_rd_count;
  assign wr_count       = r_wr_count;

endmodule

// File: tb/tb_act_sram_responder.sv
// tb_act_sram_responder
//   Directed bench for act_sram_responder (default build). A behavioural
//   model of the bank (memory array, counters, flags) is updated on every
//   clock edge and compared against the DUT on every falling edge; directed
//   scenarios add hand-computed literal expectations.

module tb_act_sram_responder;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 4096;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              eng_rd_en = 1'b0;
  logic [ADDR_W-1:0] eng_rd_addr = '0;
  logic [DATA_W-1:0] eng_rd_data;
  logic              eng_wr_en = 1'b0;
  logic [ADDR_W-1:0] eng_wr_addr = '0;
  logic [DATA_W-1:0] eng_wr_data = '0;
  logic              host_req_valid = 1'b0;
  logic              host_req_ready;
  logic              host_req_we = 1'b0;
  logic [ADDR_W-1:0] host_req_addr = '0;
  logic [DATA_W-1:0] host_req_wdata = '0;
  logic              host_rsp_valid;
  logic [DATA_W-1:0] host_rsp_rdata;
  logic              err_oob;
  logic              err_clr = 1'b0;
  logic [CNT_W-1:0]  rd_count;
  logic [CNT_W-1:0]  wr_count;

  act_sram_responder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .eng_rd_en(eng_rd_en), .eng_rd_addr(eng_rd_addr), .eng_rd_data(eng_rd_data),
    .eng_wr_en(eng_wr_en), .eng_wr_addr(eng_wr_addr), .eng_wr_data(eng_wr_data),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
    .host_req_we(host_req_we), .host_req_addr(host_req_addr),
    .host_req_wdata(host_req_wdata), .host_rsp_valid(host_rsp_valid),
    .host_rsp_rdata(host_rsp_rdata), .err_oob(err_oob), .err_clr(err_clr),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pre(input int a);
    return 8'(a * 7 + 3);
  endfunction

  function automatic logic [7:0] lut(input logic [7:0] x);
    return (x ^ 8'hA5) + 8'd1;
  endfunction

  // ---------------- behavioural model ----------------
  logic [7:0]  m_mem [DEPTH];
  logic [7:0]  m_eng_rd = '0;
  logic        m_rsp_v  = 1'b0;
  logic [7:0]  m_rsp_d  = '0;
  logic        m_oob    = 1'b0;
  logic [31:0] m_rdc    = '0;
  logic [31:0] m_wrc    = '0;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
  end

  always @(posedge clk or negedge rst_n) begin : model
    bit          acc;
    bit          err;
    int          nr;
    int          nw;
    int          ra;
    logic [7:0]  v;
    if (!rst_n) begin
      m_eng_rd = '0; m_rsp_v = 1'b0; m_rsp_d = '0;
      m_oob = 1'b0; m_rdc = '0; m_wrc = '0;
    end else begin
      acc = host_req_valid && !eng_rd_en && !eng_wr_en;
      err = 1'b0; nr = 0; nw = 0;
      // Writes land first so a same-address read sees the new word.
      if (eng_wr_en) begin
        if (int'(eng_wr_addr) < DEPTH) begin m_mem[eng_wr_addr] = eng_wr_data; nw = 1; end
        else err = 1'b1;
      end
      if (acc && host_req_we) begin
        if (int'(host_req_addr) < DEPTH) begin m_mem[host_req_addr] = host_req_wdata; nw = 1; end
        else err = 1'b1;
      end
      if (eng_rd_en || (acc && !host_req_we)) begin
        ra = eng_rd_en ? int'(eng_rd_addr) : int'(host_req_addr);
        nr = 1;
        if (ra < DEPTH) v = m_mem[ra];
        else begin v = '0; err = 1'b1; end
        m_eng_rd = v;
        if (!eng_rd_en) m_rsp_d = v;
      end
      m_rsp_v = acc;
      if (err) m_oob = 1'b1;
      else if (err_clr) m_oob = 1'b0;
      if (err_clr) begin m_rdc = '0; m_wrc = '0; end
      else begin m_rdc = m_rdc + 32'(nr); m_wrc = m_wrc + 32'(nw); end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("eng_rd_data", eng_rd_data, m_eng_rd);
      chk("host_rsp_valid", host_rsp_valid, m_rsp_v);
      chk("host_rsp_rdata", host_rsp_rdata, m_rsp_d);
      chk("err_oob", err_oob, m_oob);
      chk("rd_count", rd_count, m_rdc);
      chk("wr_count", wr_count, m_wrc);
      chk("host_req_ready", host_req_ready, !(eng_rd_en || eng_wr_en));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int         hk;
  int         acc_cnt;
  logic [7:0] x;
  logic [7:0] y;

  // One cycle of the concurrent host read stream: requests address 0x300+hk.
  task automatic host_cycle();
    host_req_valid = 1'b1;
    host_req_we    = 1'b0;
    host_req_addr  = 16'(16'h0300 + hk);
    #1;
    if (host_req_ready) begin
      hk++;
      acc_cnt++;
    end
    tick();
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk_en = 1'b1;
    chk("reset eng_rd_data", eng_rd_data, 8'h00);
    chk("reset rsp_valid", host_rsp_valid, 1'b0);
    chk("reset rd_count", rd_count, 32'd0);
    chk("reset wr_count", wr_count, 32'd0);

    // Preload the whole bank so every later read has a defined value.
    for (int a = 0; a < DEPTH; a++) begin
      eng_wr_en = 1'b1; eng_wr_addr = 16'(a); eng_wr_data = pre(a);
      tick();
    end
    eng_wr_en = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr wr_count", wr_count, 32'd0);

    // Engine write then read back.
    eng_wr_en = 1'b1; eng_wr_addr = 16'h0010; eng_wr_data = 8'h5A;
    tick();
    eng_wr_en = 1'b0; eng_rd_en = 1'b1; eng_rd_addr = 16'h0010;
    tick();
    eng_rd_en = 1'b0;
    chk("t1 rd_data", eng_rd_data, 8'h5A);
    chk("t1 wr_count", wr_count, 32'd1);
    chk("t1 rd_count", rd_count, 32'd1);

    // Same-cycle write/read is write-first.
    eng_wr_en = 1'b1; eng_wr_addr = 16'h0020; eng_wr_data = 8'h11;
    tick();
    eng_rd_en = 1'b1; eng_rd_addr = 16'h0020; eng_wr_data = 8'h33;
    tick();
    eng_rd_en = 1'b0; eng_wr_en = 1'b0;
    chk("t2 bypass", eng_rd_data, 8'h33);

    // Host read held off by three engine reads.
    host_req_valid = 1'b1; host_req_we = 1'b0; host_req_addr = 16'h0010;
    for (int i = 0; i < 3; i++) begin
      eng_rd_en = 1'b1; eng_rd_addr = 16'h0020;
      #1;
      chk("t3 ready low", host_req_ready, 1'b0);
      tick();
    end
    eng_rd_en = 1'b0;
    #1;
    chk("t3 ready high", host_req_ready, 1'b1);
    tick();
    host_req_valid = 1'b0;
    chk("t3 rsp_valid", host_rsp_valid, 1'b1);
    chk("t3 rsp_rdata", host_rsp_rdata, 8'h5A);
    tick();
    chk("t3 rsp pulse", host_rsp_valid, 1'b0);

    // Out-of-range host write.
    host_req_valid = 1'b1; host_req_we = 1'b1; host_req_addr = 16'(DEPTH); host_req_wdata = 8'h7F;
    tick();
    host_req_valid = 1'b0;
    chk("t4 ack", host_rsp_valid, 1'b1);
    chk("t4 err_oob", err_oob, 1'b1);
    chk("t4 wr_count", wr_count, 32'd3);
    chk("t4 rdata kept", host_rsp_rdata, 8'h5A);
    host_req_valid = 1'b1; host_req_we = 1'b0; host_req_addr = 16'h0000;
    tick();
    host_req_valid = 1'b0;
    chk("t4 no alias", host_rsp_rdata, pre(0));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4 clr oob", err_oob, 1'b0);
    chk("t4 clr rd", rd_count, 32'd0);
    chk("t4 clr wr", wr_count, 32'd0);

    // GELU-like engine loop with a concurrent host read stream.
    hk = 0; acc_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      eng_rd_en = 1'b1; eng_rd_addr = 16'(16'h0100 + i);
      host_cycle();
      eng_rd_en = 1'b0;
      x = eng_rd_data;
      host_cycle();
      y = lut(x);
      host_cycle();
      eng_wr_en = 1'b1; eng_wr_addr = 16'(16'h0200 + i); eng_wr_data = y;
      host_cycle();
      eng_wr_en = 1'b0;
    end
    host_req_valid = 1'b0;
    chk("t5 host grants", acc_cnt, 16);
    for (int i = 0; i < 8; i++) begin
      host_req_valid = 1'b1; host_req_we = 1'b0; host_req_addr = 16'(16'h0200 + i);
      tick();
      chk("t5 result", host_rsp_rdata, lut(pre(16'h0100 + i)));
    end
    host_req_valid = 1'b0;
    tick();

    // Reset lands on the edge that would deliver a host response.
    host_req_valid = 1'b1; host_req_we = 1'b1; host_req_addr = 16'h0040; host_req_wdata = 8'h99;
    tick();
    host_req_we = 1'b0;
    #1;
    chk("t6 accept", host_req_ready, 1'b1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    host_req_valid = 1'b0;
    tick();
    chk("t6 rsp dropped", host_rsp_valid, 1'b0);
    chk("t6 eng_rd_data", eng_rd_data, 8'h00);
    chk("t6 rsp_rdata", host_rsp_rdata, 8'h00);
    chk("t6 err_oob", err_oob, 1'b0);
    chk("t6 rd_count", rd_count, 32'd0);
    chk("t6 wr_count", wr_count, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    host_req_valid = 1'b1; host_req_we = 1'b0; host_req_addr = 16'h0040;
    tick();
    host_req_valid = 1'b0;
    chk("t6 write kept", host_rsp_rdata, 8'h99);
    tick();
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/act_sram_responder.md
Name: act_sram_responder

Overview:
Activation scratchpad SRAM bank that services the SRAM read and write ports driven by element-wise op engines (GELU, softmax, layernorm). The engine-side port has fixed timing and no backpressure: a read returns data exactly one cycle after rd_en, and a write commits on the cycle wr_en is high. A lower-priority host/DMA port with a valid/ready handshake shares the bank and only gets cycles the engine leaves idle. The block also keeps bounds-error status and access counters.

Parameters:
DATA_W, 8, word width in bits (matches npu_pkg DATA_W).
ADDR_W, 16, address width of every port.
DEPTH, 4096, number of words implemented; addresses >= DEPTH are out of range.
CNT_W, 32, width of the access counters.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
eng_rd_en  in  1  engine read strobe
eng_rd_addr  in  ADDR_W  engine read address
eng_rd_data  out  DATA_W  engine read data, valid the cycle after eng_rd_en
eng_wr_en  in  1  engine write strobe
eng_wr_addr  in  ADDR_W  engine write address
eng_wr_data  in  DATA_W  engine write data
host_req_valid  in  1  host request valid
host_req_ready  out  1  host request accepted this cycle when valid&ready
host_req_we  in  1  1 = write, 0 = read
host_req_addr  in  ADDR_W  host address
host_req_wdata  in  DATA_W  host write data
host_rsp_valid  out  1  one-cycle pulse, the cycle after acceptance
host_rsp_rdata  out  DATA_W  host read data, qualified by host_rsp_valid and !host_req_we of the accepted request
err_oob  out  1  sticky out-of-range access flag
err_clr  in  1  clears err_oob and both counters
rd_count  out  CNT_W  granted reads (engine + host)
wr_count  out  CNT_W  committed in-range writes (engine + host)

Behaviour:
- Reset (async, rst_n low) clears the following to 0: eng_rd_data, host_rsp_valid, host_rsp_rdata, err_oob, rd_count, wr_count. Memory contents are not reset.
- Storage: DEPTH x DATA_W array with 1 synchronous read port and 1 write port.
- Engine read: on eng_rd_en at cycle N, eng_rd_data is registered with mem[eng_rd_addr] at the end of N and is valid throughout N+1. eng_rd_data holds its last value until the next read (engine or host).
- Engine write: on eng_wr_en, mem[eng_wr_addr] is updated at the clock edge.
- Engine read and engine write in the same cycle to the same address are write-first: the read returns eng_wr_data.
- Host arbitration: host_req_ready = !eng_rd_en && !eng_wr_en. The engine always wins and is never stalled. The host holds valid and request fields stable until ready.
- Host accepted at cycle N:
  - Read: host_rsp_rdata = mem[addr] and host_rsp_valid = 1 in N+1.
  - Write: commits at the edge of N; host_rsp_valid = 1 in N+1 as an ack, and host_rsp_rdata is unchanged.
- Back-to-back host accepts are allowed, one per cycle.
- Out of range (addr >= DEPTH) on any granted access:
  - A read returns 0.
  - A write is dropped and wr_count is not incremented.
  - err_oob is set at the next edge.
- err_oob is sticky until err_clr. If err_clr and a new error occur in the same cycle, set wins.
- Counters: rd_count increments by the number of granted reads in the cycle (0..1; engine and host reads are mutually exclusive). wr_count increments likewise. Counters wrap modulo 2^CNT_W.
- err_clr zeroes both counters; any access in the same cycle is not counted.
- Reset mid-operation: a pending host_rsp_valid is dropped, and any write already clocked stays committed.

Optional Feature:
ACT_SRAM_PARITY_EN
- Defined: each word stores an extra even-parity bit computed on write. Every read checks parity. A mismatch sets an extra output, err_parity, with the same sticky, err_clr and set-wins rules as err_oob. The read data is returned unmodified. A test-only input, inj_par_err, flips the stored parity bit of the write on that cycle.
- Undefined: no parity storage, and neither err_parity nor inj_par_err exists.

Test Plan:
- Engine writes 0x5A to addr 0x0010, then reads addr 0x0010 next cycle -> eng_rd_data = 0x5A in the following cycle; wr_count = 1, rd_count = 1.
- Same-cycle engine write 0x33 and read of addr 0x0020 (old value 0x11) -> eng_rd_data = 0x33 next cycle.
- Host read of 0x0010 held valid while eng_rd_en is high for 3 cycles -> host_req_ready = 0 for those 3 cycles; accepted on the 4th; host_rsp_valid one cycle later with rdata 0x5A.
- Host write 0x7F to addr DEPTH (4096) -> ack pulse, memory unchanged, err_oob = 1, wr_count unchanged. err_clr -> err_oob = 0 and counters = 0.
- Emulated GELU engine pattern (4-cycle READ/WAIT/LUT/WRITE loop, length 8, src 0x0100, dst 0x0200) with a concurrent host read stream -> all 8 engine results correct, and host reads are granted only in non-engine cycles.
- Reset asserted the cycle after a host read accept -> host_rsp_valid stays 0 and every output is 0 after reset.
